// File: rtl/uart_rx16.sv
// uart_rx16 -- 8N1 serial receiver assembling two consecutive bytes into one 16-bit word,
// with framing-error and inter-byte timeout reporting. Rev 1.0
`default_nettype none

module uart_rx16 #(
  parameter int CLKS_PER_BIT = 5,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_in,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_err
);

  localparam int CW = $clog2(GAP_BITS * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_GAP   = 3'd4
  } state_e;

  state_e        state_q;
  logic          s_meta_q;
  logic          s_sync_q;
  logic          slot_hi_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] gap_q;
  logic [3:0]    idx_q;
  logic [7:0]    byte_q;
  logic [7:0]    hold_q;
  logic [15:0]   data_q;
  logic          valid_q;
  logic          err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q  <= 1'b1;
      s_sync_q  <= 1'b1;
      state_q   <= R_IDLE;
      slot_hi_q <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
      idx_q     <= 4'd0;
      byte_q    <= 8'h00;
      hold_q    <= 8'h00;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_meta_q <= s_in;
      s_sync_q <= s_meta_q;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (!s_sync_q) begin
            cnt_q   <= '0;
            state_q <= R_START;
          end
        end
        R_START: begin
          if (cnt_q == HALF) begin
            if (!s_sync_q) begin
              cnt_q   <= '0;
              idx_q   <= 4'd0;
              state_q <= R_DATA;
            end else begin
              state_q <= R_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        R_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q                <= '0;
            byte_q[idx_q[2:0]]   <= s_sync_q;
            if (idx_q == 4'd7) begin
              state_q <= R_STOP;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        R_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (!s_sync_q) begin
              err_q     <= 1'b1;
              slot_hi_q <= 1'b0;
              hold_q    <= 8'h00;
              state_q   <= R_IDLE;
            end else if (!slot_hi_q) begin
              hold_q    <= byte_q;
              slot_hi_q <= 1'b1;
              gap_q     <= '0;
              state_q   <= R_GAP;
            end else begin
              data_q    <= {byte_q, hold_q};
              valid_q   <= 1'b1;
              slot_hi_q <= 1'b0;
              state_q   <= R_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        R_GAP: begin
          // A falling edge wins over a timeout landing on the same cycle.
          if (!s_sync_q) begin
            cnt_q   <= '0;
            state_q <= R_START;
          end else if (gap_q == GAP_LAST) begin
            err_q     <= 1'b1;
            slot_hi_q <= 1'b0;
            hold_q    <= 8'h00;
            state_q   <= R_IDLE;
          end else begin
            gap_q <= gap_q + ONE;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16 -- directed and randomized frames checked against a word-level receive model.
`default_nettype none

module tb_uart_rx16;

  localparam int CPB = 5;
  localparam int GAP = 20;

  logic        clk;
  logic        rst_n;
  logic        s_in;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_err;

  uart_rx16 #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_in   (s_in),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_err  (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observations
  logic [15:0] got_q[$];
  int          n_err_obs = 0;
  int          n_both    = 0;

  // Reference model state: words are pairs of good frames, errors from bad stops or long gaps
  logic [15:0] exp_q[$];
  int          exp_err  = 0;
  bit          have_low = 1'b0;
  logic [7:0]  low_byte = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) got_q.push_back(o_data);
      if (o_err) n_err_obs++;
      if (o_valid && o_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    s_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    s_in = stop_ok;
    repeat (CPB) @(negedge clk);
    s_in = 1'b1;
    if (!stop_ok) begin
      exp_err++;
      have_low = 1'b0;
    end else if (!have_low) begin
      have_low = 1'b1;
      low_byte = b;
    end else begin
      exp_q.push_back({b, low_byte});
      have_low = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    s_in = 1'b1;
    repeat (n) @(negedge clk);
    if (n > GAP * CPB + 10 && have_low) begin
      exp_err++;
      have_low = 1'b0;
    end
  endtask

  task automatic check_scn(input string tag);
    @(posedge clk);
    #2;
    chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, {16'h0, got_q[i]}, {16'h0, exp_q[i]});
    chk({tag, "_nerr"}, n_err_obs, exp_err);
    chk({tag, "_both"}, n_both, 0);
    got_q.delete();
    exp_q.delete();
    n_err_obs = 0;
    exp_err   = 0;
    n_both    = 0;
  endtask

  initial begin
    logic [15:0] w;
    s_in  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_data", {16'h0, o_data}, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_err", {31'h0, o_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // Basic back-to-back word
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    idle(20);
    check_scn("word1234");

    // Framing error, then recovery
    send_frame(8'hA5, 1'b0);
    idle(20);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle(20);
    check_scn("frame_err");

    // Inter-byte timeout, then recovery
    send_frame(8'h55, 1'b1);
    idle(150);
    send_frame(8'hCD, 1'b1);
    send_frame(8'hAB, 1'b1);
    idle(20);
    check_scn("gap_timeout");

    // Single-clock glitch on idle line, then a normal word
    s_in = 1'b0;
    @(negedge clk);
    s_in = 1'b1;
    idle(30);
    check_scn("glitch");
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check_scn("post_glitch");

    // Asynchronous reset during bit 4 of the high byte
    send_frame(8'h77, 1'b1);
    s_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_in = 1'b0 ^ i[0];
      repeat (CPB) @(negedge clk);
    end
    s_in = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_data", {16'h0, o_data}, 32'h0);
    chk("midrst_valid", {31'h0, o_valid}, 32'h0);
    chk("midrst_err", {31'h0, o_err}, 32'h0);
    have_low = 1'b0;
    s_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    check_scn("after_rst");
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(20);
    check_scn("word00FF");

    // Three words with no idle between frames
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    idle(20);
    check_scn("three_words");

    // Randomized words with short random gaps
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      send_frame(w[7:0], 1'b1);
      idle($urandom_range(0, 15));
      send_frame(w[15:8], 1'b1);
      idle($urandom_range(0, 10));
    end
    idle(20);
    check_scn("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx16.md
UART_RX16 -- requirements
Module: uart_rx16

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5, SHALL set the clock cycles per serial bit (48 kHz clock / 9600 baud).
REQ-002 Parameter GAP_BITS, default 20, SHALL set the maximum idle bit-times allowed between the low byte's stop bit and the high byte's start bit.
REQ-003 clk  input  1  SHALL be the single rising-edge clock for all logic.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 s_in  input  1  SHALL be the serial line; idle is high.
REQ-006 o_data  output  16  SHALL hold the last completed word: first received byte in [7:0], second byte in [15:8].
REQ-007 o_valid  output  1  SHALL pulse high for one clk cycle when o_data is updated.
REQ-008 o_err  output  1  SHALL pulse high for one clk cycle on a framing error or inter-byte timeout.

Function
REQ-009 s_in SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (s_sync).
REQ-010 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-011 The FSM SHALL have the states R_IDLE, R_START, R_DATA, R_STOP and R_GAP.
REQ-012 R_IDLE: on s_sync=0, the bit counter SHALL clear and the FSM SHALL go to R_START.
REQ-013 R_START: at count CLKS_PER_BIT/2 (integer division, =2), a sampled 0 SHALL clear the counter and go to R_DATA; a sampled 1 (glitch) SHALL return to R_IDLE with no error.
REQ-014 R_DATA: every CLKS_PER_BIT cycles thereafter (mid-bit), s_sync SHALL be shifted into the byte register at the current index (0..7); after index 7 the FSM SHALL go to R_STOP.
REQ-015 R_STOP: CLKS_PER_BIT cycles after bit 7, s_sync SHALL be sampled; 1 = byte good, 0 = framing error.
REQ-016 Framing error SHALL pulse o_err, discard any partial word, set byte slot to low, and go to R_IDLE.
REQ-017 Good low byte SHALL be stored in a holding register, set byte slot to high, clear the gap counter, and go to R_GAP.
REQ-018 Good high byte SHALL load o_data = {high byte, held low byte}, pulse o_valid in the following cycle, set byte slot to low, and go to R_IDLE.
REQ-019 R_GAP: s_sync=0 SHALL go to R_START with the byte slot kept high; if GAP_BITS*CLKS_PER_BIT cycles elapse first, o_err SHALL pulse, the low byte SHALL be discarded, slot set to low, FSM to R_IDLE.
REQ-020 A start bit beginning on the same cycle as a mid-stop sample completion SHALL be detected (back-to-back frames, stop bit of at least one half bit-time).
REQ-021 o_data SHALL hold its value between o_valid pulses; o_valid and o_err SHALL never be high in the same cycle.
REQ-022 Counters SHALL be wide enough for GAP_BITS*CLKS_PER_BIT without wrap; bit index 4 bits, saturating at 7.

Reset
REQ-023 rst_n=0 SHALL immediately force FSM=R_IDLE, slot=low, o_data=16'h0000, o_valid=0, o_err=0, all counters and registers 0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new falling edge, with no o_valid or o_err.

Verification
REQ-025 Send bytes 8'h34 then 8'h12 back-to-back, 8N1 at 5 clk/bit -> one o_valid pulse, o_data=16'h1234, o_err never high.
REQ-026 Send 8'hA5 with stop bit forced 0 -> o_err pulse once, no o_valid; a following 8'h01, 8'h02 pair -> o_data=16'h0201.
REQ-027 Send 8'h55, then idle longer than 100 clk -> o_err pulse at gap expiry; then 8'hCD, 8'hAB -> o_data=16'hABCD.
REQ-028 Drive a 1-clk low glitch on idle s_in -> no o_valid, no o_err, FSM returns to R_IDLE.
REQ-029 Assert rst_n during bit 4 of the high byte -> outputs 0 immediately; then send 8'hFF, 8'h00 -> o_data=16'h00FF.
REQ-030 Send 3 words (16'h0000, 16'hFFFF, 16'h8001) with no idle between frames -> exactly 3 o_valid pulses with matching o_data.
